carry_lookahead_adder_4bit: RTL and testbench
=============================================

# carry_lookahead_adder_4bit

Registered 4-bit carry-lookahead adder computing `result = a + b + c_in`, with carry-out, signed-overflow flag and group propagate/generate outputs. Carries come from a two-level lookahead network, not a ripple chain. It is the leaf adder slice of the MIPS ALU. Wider adders chain it through `c_out`, or through `group_p`/`group_g` into a higher-level lookahead unit.

## Interface
- No parameters; width fixed at 4 bits.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all registers.
- `in_valid` input 1: qualifies `a`, `b`, `c_in` this cycle.
- `a` input 4: addend A, unsigned or two's complement.
- `b` input 4: addend B.
- `c_in` input 1: carry into bit 0.
- `result` output 4: registered sum bits [3:0].
- `c_out` output 1: registered carry out of bit 3.
- `overflow` output 1: registered signed overflow, c4 XOR c3.
- `group_p` output 1: registered group propagate, p3&p2&p1&p0.
- `group_g` output 1: registered group generate, g3 | p3g2 | p3p2g1 | p3p2p1g0.
- `out_valid` output 1: high for one cycle when outputs hold a new result.

## Operation
- Per bit: generate gi = ai&bi; propagate pi = ai^bi.
- Carries, all flattened with no ripple dependency:
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
  - c0 = c_in.
- Sum bits: si = pi ^ ci.
- Width rules: {c_out, result} equals the 5-bit value a + b + c_in exactly. Overflow is set iff a and b have equal sign bits and result[3] differs from them.
- `group_p`/`group_g` do not depend on `c_in`.
- When `in_valid` = 1, the outputs register loads all five computed values on the rising edge.
- When `in_valid` = 0, output registers hold their previous values and `out_valid` deasserts.
- `in_valid` may be held high on consecutive cycles: full throughput, one addition per cycle, no back-pressure.
- The result is undefined by no input value; every combination of 9 input bits is legal.

## Timing
- Latency: 1 cycle. Operands sampled at edge N appear on the outputs immediately after edge N; `out_valid` is high during cycle N+1.
- Critical path: pi/gi, then one AND-OR lookahead level, then XOR. This is 3 logic levels with no dependency on lower carries.
- Reset value of every output is 0: `result`=0, `c_out`=0, `overflow`=0, `group_p`=0, `group_g`=0, `out_valid`=0.
- Reset takes effect asynchronously, including mid-stream. The first edge after deassertion with `in_valid`=1 produces a normal result.
- If `reset` and a clock edge coincide, reset wins.

## Structure
- Sub-module `cla_logic_4bit` is purely combinational. Inputs: a, b, c_in. Outputs: sum, c_out, c3, group_p, group_g.
- Top level adds the output register bank, the overflow XOR and the valid flop.
- Width constant (4) and the carry/generate equations' bit-index constants go in the shared ALU package. No typedefs are needed.

## Test plan
- Reset asserted asynchronously between edges: all outputs 0 immediately; `out_valid`=0.
- a=1, b=2, c_in=0, `in_valid`=1 → next cycle `result`=3, `c_out`=0, `overflow`=0, `out_valid`=1.
- a=3, b=11, c_in=1 → `result`=15, `c_out`=0, `overflow`=0 (3 + (−5) + 1 = −1).
- a=15, b=0, c_in=1 (full propagate) → `result`=0, `c_out`=1, `group_p`=1, `group_g`=0.
- a=7, b=1, c_in=0 → `result`=8, `c_out`=0, `overflow`=1. Then a=8, b=8, c_in=0 → `result`=0, `c_out`=1, `overflow`=1, `group_g`=1.
- Exhaustive sweep of all 512 (a, b, c_in) combinations, back to back: each result matches the 5-bit sum one cycle later. Then drop `in_valid` → outputs hold and `out_valid`=0.

Source files
------------

// File: rtl/carry_lookahead_adder_4bit_pkg.sv
// Purpose: shared ALU constants for the 4-bit carry-lookahead adder slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: slice width and the bit-index constants used by the carry/generate equations.
package carry_lookahead_adder_4bit_pkg;

   localparam int WIDTH = 4;

   // Bit positions named so the flattened lookahead equations read like the math.
   localparam int B0 = 0;
   localparam int B1 = 1;
   localparam int B2 = 2;
   localparam int B3 = 3;

endpackage

// File: rtl/carry_lookahead_adder_4bit_cla_logic.sv
// Purpose: combinational 4-bit two-level carry-lookahead network.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b, c_in in; sum, c_out (c4), c3, group_p, group_g out.
module cla_logic_4bit
   import carry_lookahead_adder_4bit_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             c3,
   output logic             group_p,
   output logic             group_g
);

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic             c1;
   logic             c2;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a single AND-OR level over p/g and c_in; no carry
   // depends on a lower carry, so the path is p/g -> AND-OR -> XOR.
   assign c1 = g[B0]
             | (p[B0] & c_in);

   assign c2 = g[B1]
             | (p[B1] & g[B0])
             | (p[B1] & p[B0] & c_in);

   assign c3 = g[B2]
             | (p[B2] & g[B1])
             | (p[B2] & p[B1] & g[B0])
             | (p[B2] & p[B1] & p[B0] & c_in);

   assign c_out = g[B3]
                | (p[B3] & g[B2])
                | (p[B3] & p[B2] & g[B1])
                | (p[B3] & p[B2] & p[B1] & g[B0])
                | (p[B3] & p[B2] & p[B1] & p[B0] & c_in);

   assign sum = p ^ {c3, c2, c1, c_in};

   // Group terms exclude c_in so a higher-level lookahead unit can use them.
   assign group_p = p[B3] & p[B2] & p[B1] & p[B0];

   assign group_g = g[B3]
                  | (p[B3] & g[B2])
                  | (p[B3] & p[B2] & g[B1])
                  | (p[B3] & p[B2] & p[B1] & g[B0]);

endmodule

// File: rtl/carry_lookahead_adder_4bit.sv
// Purpose: registered 4-bit CLA slice: result = a + b + c_in with carry, overflow, group P/G.
// Latency: 1 cycle; one addition per cycle at full throughput.
// Backpressure: none; in_valid=0 holds the outputs and drops out_valid.
// Ports: clk, reset (async, active-high), in_valid, a, b, c_in in;
//        result, c_out, overflow, group_p, group_g, out_valid out (all registered).
module carry_lookahead_adder_4bit
   import carry_lookahead_adder_4bit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow,
   output logic             group_p,
   output logic             group_g,
   output logic             out_valid
);

   logic [WIDTH-1:0] sum_nxt;
   logic             c4_nxt;
   logic             c3_nxt;
   logic             gp_nxt;
   logic             gg_nxt;
   logic             ovf_nxt;

   cla_logic_4bit u_cla (
      .a       (a),
      .b       (b),
      .c_in    (c_in),
      .sum     (sum_nxt),
      .c_out   (c4_nxt),
      .c3      (c3_nxt),
      .group_p (gp_nxt),
      .group_g (gg_nxt)
   );

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign ovf_nxt = c4_nxt ^ c3_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= '0;
         c_out     <= 1'b0;
         overflow  <= 1'b0;
         group_p   <= 1'b0;
         group_g   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result   <= sum_nxt;
            c_out    <= c4_nxt;
            overflow <= ovf_nxt;
            group_p  <= gp_nxt;
            group_g  <= gg_nxt;
         end
      end
   end

endmodule

// File: tb/tb_carry_lookahead_adder_4bit.sv
// Purpose: self-checking bench for carry_lookahead_adder_4bit against an arithmetic model.
// Latency: checks outputs one cycle after each sampled operand set.
// Backpressure: n/a (DUT has none).
module tb_carry_lookahead_adder_4bit;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       c_in;
   logic [3:0] result;
   logic       c_out;
   logic       overflow;
   logic       group_p;
   logic       group_g;
   logic       out_valid;

   // Model state: what the outputs must show right now.
   logic [3:0] exp_result;
   logic       exp_c_out;
   logic       exp_overflow;
   logic       exp_group_p;
   logic       exp_group_g;
   logic       exp_valid;

   int n_checks;
   int n_fail;

   carry_lookahead_adder_4bit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .result    (result),
      .c_out     (c_out),
      .overflow  (overflow),
      .group_p   (group_p),
      .group_g   (group_g),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Model update from plain integer arithmetic.
   task automatic model_load(input int av, input int bv, input int cv);
      int s;
      s = av + bv + cv;
      exp_result   = s[3:0];
      exp_c_out    = (s > 15);
      exp_overflow = (av[3] == bv[3]) && (s[3] != av[3]);
      exp_group_p  = ((av ^ bv) == 15);
      exp_group_g  = ((av + bv) > 15);
   endtask

   task automatic model_clear();
      exp_result   = 4'd0;
      exp_c_out    = 1'b0;
      exp_overflow = 1'b0;
      exp_group_p  = 1'b0;
      exp_group_g  = 1'b0;
      exp_valid    = 1'b0;
   endtask

   // Drive one cycle of stimulus at the falling edge; update the model just after the rising edge.
   task automatic apply(input int av, input int bv, input int cv, input bit v);
      @(negedge clk);
      a        = av[3:0];
      b        = bv[3:0];
      c_in     = cv[0];
      in_valid = v;
      @(posedge clk);
      #1;
      exp_valid = v;
      if (v) model_load(av, bv, cv);
   endtask

   // Hand-computed literal expectations, applied to both the DUT and the model.
   task automatic expect_lit(input string tag, input int r, input int co, input int ov,
                             input int gp, input int gg, input int vl);
      check({tag, ".result"},    result,    r);
      check({tag, ".c_out"},     c_out,     co);
      check({tag, ".overflow"},  overflow,  ov);
      check({tag, ".group_p"},   group_p,   gp);
      check({tag, ".group_g"},   group_g,   gg);
      check({tag, ".out_valid"}, out_valid, vl);
      check({tag, ".model_result"}, exp_result, r);
      check({tag, ".model_c_out"},  exp_c_out,  co);
      check({tag, ".model_ovf"},    exp_overflow, ov);
      check({tag, ".model_gp"},     exp_group_p,  gp);
      check({tag, ".model_gg"},     exp_group_g,  gg);
   endtask

   // Single compare process: DUT vs model every falling edge.
   always @(negedge clk) begin
      check("cmp.result",    result,    exp_result);
      check("cmp.c_out",     c_out,     exp_c_out);
      check("cmp.overflow",  overflow,  exp_overflow);
      check("cmp.group_p",   group_p,   exp_group_p);
      check("cmp.group_g",   group_g,   exp_group_g);
      check("cmp.out_valid", out_valid, exp_valid);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      a        = 4'd0;
      b        = 4'd0;
      c_in     = 1'b0;
      model_clear();

      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      expect_lit("reset_state", 0, 0, 0, 0, 0, 0);

      apply(1, 2, 0, 1'b1);
      expect_lit("add_1_2", 3, 0, 0, 0, 0, 1);

      // Asynchronous reset in the middle of the high phase, with a valid
      // operand pending so the coinciding edge shows that reset wins.
      #2;
      a        = 4'd5;
      b        = 4'd5;
      c_in     = 1'b0;
      in_valid = 1'b1;
      reset    = 1'b1;
      #1;
      model_clear();
      check("async_reset.result",    result,    0);
      check("async_reset.out_valid", out_valid, 0);
      check("async_reset.c_out",     c_out,     0);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("reset_wins.result",    result,    0);
      check("reset_wins.out_valid", out_valid, 0);
      reset = 1'b0;

      apply(3, 11, 1, 1'b1);
      expect_lit("add_3_m5_1", 15, 0, 0, 0, 0, 1);
      apply(15, 0, 1, 1'b1);
      expect_lit("full_prop", 0, 1, 0, 1, 0, 1);
      apply(7, 1, 0, 1'b1);
      expect_lit("ovf_pos", 8, 0, 1, 0, 0, 1);
      apply(8, 8, 0, 1'b1);
      expect_lit("ovf_neg", 0, 1, 1, 0, 1, 1);

      // Exhaustive back-to-back sweep; the compare process checks each result.
      for (int cv = 0; cv < 2; cv++)
         for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
               apply(av, bv, cv, 1'b1);
      expect_lit("sweep_last", 15, 1, 0, 0, 1, 1);

      // Drop in_valid with different operands: outputs must hold.
      apply(1, 1, 0, 1'b0);
      expect_lit("hold_1", 15, 1, 0, 0, 1, 0);
      apply(2, 3, 1, 1'b0);
      expect_lit("hold_2", 15, 1, 0, 0, 1, 0);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
